exp_table_sink: RTL

Receive side of the exp(mu) table stream: accepts the 64 `(oData, oAddr, oValid, oDone)` writes that `CalculateExpMu` emits after `iStart`, stores them in a 64×17 table, and checks completeness and duplicates. It also accumulates the running sum of all entries. Once the table is complete it is locked and served to the downstream risk datapath through a 1-cycle-latency random read port.

---
 rtl/risk_pkg.sv | 16 +
 rtl/exp_table_sink_if.sv | 31 +++
 rtl/exp_table_ram.sv | 34 +++
 rtl/exp_table_sink.sv | 132 +++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// Shared definitions for the exp(mu) table path.
// Holds the table geometry used by both the producer (CalculateExpMu) and the
// receiving sink, plus the sink state encoding.
package risk_pkg;

  localparam int EXP_DATA_W = 17;
  localparam int EXP_ADDR_W = 6;
  localparam int EXP_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } exp_sink_state_t;

endpackage

// File: rtl/exp_table_sink_if.sv
// Interface bundling the exp table write stream and the random read port.
// Write stream : iData, iAddr, iValid, iDone   (producer -> sink)
// Read port    : iRdEn, iRdAddr                (consumer -> sink)
//                oRdData, oRdValid             (sink -> consumer)
// master modport: the side driving writes and read requests.
// slave  modport: the table sink.
interface exp_table_sink_if #(
  parameter int DATA_W = risk_pkg::EXP_DATA_W,
  parameter int ADDR_W = risk_pkg::EXP_ADDR_W
);

  logic [DATA_W-1:0] iData;
  logic [ADDR_W-1:0] iAddr;
  logic              iValid;
  logic              iDone;
  logic              iRdEn;
  logic [ADDR_W-1:0] iRdAddr;
  logic [DATA_W-1:0] oRdData;
  logic              oRdValid;

  modport master (
    output iData, iAddr, iValid, iDone, iRdEn, iRdAddr,
    input  oRdData, oRdValid
  );

  modport slave (
    input  iData, iAddr, iValid, iDone, iRdEn, iRdAddr,
    output oRdData, oRdValid
  );

endinterface

// File: rtl/exp_table_ram.sv
// Simple dual-port table storage: one write port, one registered read port.
// Ports:
//   CLK      clock
//   wr_en    write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    read strobe, rd_data updated on the rising edge
//   rd_addr  read index
//   rd_data  registered read data (holds its value when rd_en is low)
// The read register has no reset so the array plus read register map onto a
// block RAM primitive.
module exp_table_ram #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/exp_table_sink.sv
// Receive side of the exp(mu) table stream.
// Collects one write per table address during FILL, tracks which addresses
// have been seen (bitmap), accumulates the sum of first-seen entries, flags
// duplicates and incomplete tables, then locks the table in READY and serves
// 1-cycle-latency reads.
// Ports:
//   CLK          clock, rising edge
//   iRst         synchronous active-high reset
//   iArm         pulse: clear bitmap/sum/flags and start a fill (any state)
//   bus          write stream + read port (slave side)
//   oBusy        high while filling
//   oReady       high while the table is complete and locked
//   oSum         sum of unique entries written since the last arm
//   oErrDup      sticky: an address was written twice in one fill
//   oErrMissing  sticky: end-of-table arrived with addresses missing
module exp_table_sink
  import risk_pkg::*;
#(
  parameter int DATA_W = EXP_DATA_W,
  parameter int ADDR_W = EXP_ADDR_W,
  parameter int SUM_W  = DATA_W + ADDR_W
) (
  input  logic               CLK,
  input  logic               iRst,
  input  logic               iArm,
  exp_table_sink_if.slave    bus,
  output logic               oBusy,
  output logic               oReady,
  output logic [SUM_W-1:0]   oSum,
  output logic               oErrDup,
  output logic               oErrMissing
);

  localparam int DEPTH = 2**ADDR_W;

  exp_sink_state_t   state_reg;
  logic [DEPTH-1:0]  bitmap_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic              err_dup_reg;
  logic              err_missing_reg;
  logic              rd_valid_reg;

  logic [DEPTH-1:0]  addr_hit;
  logic [DEPTH-1:0]  bitmap_wr;
  logic              hit_set;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] ram_rd_data;

  // One-hot decode of the write address.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign addr_hit[gi] = (bus.iAddr == ADDR_W'(gi));
  end

  assign hit_set = |(bitmap_reg & addr_hit);
  // Bitmap including this cycle's write, so a write coinciding with iDone
  // is part of the completeness check.
  assign bitmap_wr = bitmap_reg | (bus.iValid ? addr_hit : '0);

  // Arm takes priority over a same-cycle write or read.
  assign wr_en = (state_reg == FILL)  && bus.iValid && !iArm;
  assign rd_en = (state_reg == READY) && bus.iRdEn  && !iArm;

  exp_table_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (bus.iAddr),
    .wr_data (bus.iData),
    .rd_en   (rd_en),
    .rd_addr (bus.iRdAddr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge CLK) begin
    if (iRst) begin
      state_reg       <= IDLE;
      bitmap_reg      <= '0;
      sum_reg         <= '0;
      err_dup_reg     <= 1'b0;
      err_missing_reg <= 1'b0;
      rd_valid_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (iArm) begin
        state_reg       <= FILL;
        bitmap_reg      <= '0;
        sum_reg         <= '0;
        err_dup_reg     <= 1'b0;
        err_missing_reg <= 1'b0;
      end else begin
        case (state_reg)
          FILL: begin
            if (bus.iValid) begin
              bitmap_reg <= bitmap_wr;
              // A rewrite replaces the stored entry but the sum keeps the
              // first value.
              if (hit_set) begin
                err_dup_reg <= 1'b1;
              end else begin
                sum_reg <= sum_reg + SUM_W'(bus.iData);
              end
            end
            if (bus.iDone) begin
              if (&bitmap_wr) begin
                state_reg <= READY;
              end else begin
                err_missing_reg <= 1'b1;
                state_reg       <= IDLE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The RAM read register is not reset; present zero whenever no read
  // result is valid.
  assign bus.oRdData  = rd_valid_reg ? ram_rd_data : '0;
  assign bus.oRdValid = rd_valid_reg;
  assign oBusy        = (state_reg == FILL);
  assign oReady       = (state_reg == READY);
  assign oSum         = sum_reg;
  assign oErrDup      = err_dup_reg;
  assign oErrMissing  = err_missing_reg;

endmodule
